fifo_prog: RTL and testbench
============================

Name: fifo_prog

Overview:
- Second-generation synchronous FIFO. Single clock, show-ahead read, runtime-programmable almost-full/almost-empty thresholds.
- Sticky overflow/underflow error flags, synchronous flush, and support for non-power-of-two DEPTH.
- Drop-in successor to the existing FIFO wherever producers need early back-pressure or error visibility, e.g. between packet parsers and DMA engines.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- DEPTH, 16, number of entries; any value >= 2, power of two not required.
- CW, $clog2(DEPTH+1), width of count and threshold buses (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO contents.
- wr_en  in  1  push request.
- wr_data  in  DATA_WIDTH  push data.
- rd_en  in  1  pop request.
- rd_data  out  DATA_WIDTH  head-of-queue data (show-ahead).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CW  current occupancy.
- af_thresh  in  CW  almost-full threshold.
- ae_thresh  in  CW  almost-empty threshold.
- almost_full  out  1  count >= af_thresh.
- almost_empty  out  1  count <= ae_thresh.
- overflow  out  1  sticky: push attempted while full and not accepted.
- underflow  out  1  sticky: pop attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow (and peak, if enabled).

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = count = 0.
  - empty = 1, full = 0, almost_empty = 1 (ae_thresh >= 0).
  - almost_full = (af_thresh == 0).
  - overflow = underflow = 0.
  - rd_data is don't-care; memory is not reset.
- Read path: rd_data = mem[rd_ptr] combinationally, valid whenever empty == 0. Zero read latency; rd_en advances rd_ptr at the posedge.
- Push accepted at posedge when wr_en && (!full || rd_en). A push at full with a simultaneous pop is accepted (pass-through; count stays DEPTH).
- Pop accepted at posedge when rd_en && !empty. A pop at empty with a simultaneous push is not accepted: the word is written, count becomes 1, and underflow is set.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both accepted: unchanged.
  - neither accepted: unchanged.
- Pointers increment by one and wrap from DEPTH-1 to 0 by explicit compare (not modulo 2^n).
- Flags full, empty, almost_full and almost_empty are decoded combinationally from the count register. They are valid in the same cycle count updates; no extra latency.
- Threshold inputs are sampled live. Values above DEPTH are legal: almost_full never asserts, almost_empty always asserts.
- overflow set on wr_en && full && !rd_en. underflow set on rd_en && empty. Both hold until clr_err or reset.
- If clr_err and a new error occur in the same cycle, set wins.
- flush (synchronous, highest priority after reset):
  - pointers and count go to 0; wr_en and rd_en are ignored that cycle.
  - error flags are unaffected.
- No internal FSM beyond pointer/count registers. The optional peak logic adds one register.

Optional Feature:
- Macro FIFO_PEAK_EN.
- Defined:
  - extra output port peak  out  CW, a high-water mark.
  - peak <= max(peak, next_count) each cycle; cleared to 0 by reset or clr_err.
  - flush does not clear peak.
- Undefined: port and register are absent, and behaviour is otherwise identical.

Decomposition:
- Package fifo_pkg holds:
  - function cnt_w(depth) returning $clog2(depth+1).
  - function ptr_w(depth) returning max(1,$clog2(depth)).
  - typedef fifo_err_t, a packed struct {overflow, underflow}, for reuse by status registers.
- Sub-module fifo_mem_2p (parameters DATA_WIDTH, DEPTH):
  - synchronous write, asynchronous read register array.
  - keeps storage swappable for SRAM macros later.

Test Plan (DATA_WIDTH=8, DEPTH=12 to exercise non-power-of-two wrap, af_thresh=10, ae_thresh=2):
- Reset, then pop with empty -> rd_data unchecked, count=0, underflow=1. clr_err one cycle -> underflow=0.
- Push 0x00..0x0B -> count steps 1..12; almost_empty deasserts at count=3; almost_full asserts at count=10; full=1 at 12. Push 0xAA at full -> count=12, overflow=1, 0xAA never read.
- Pop 12 words -> data 0x00..0x0B in order; empty=1 after the last pop. Then 20 alternating push/pop cycles of 0x80+k -> pointers wrap past index 11, data matches in order.
- Fill to 12, then assert wr_en and rd_en together with 0x55 -> head popped, count stays 12, overflow unchanged. 0x55 emerges after 11 further pops.
- At empty, assert wr_en=1 (0x33) and rd_en=1 together -> count=1, rd_data=0x33, underflow=1. Fill to 7, assert flush with wr_en=1 -> count=0, empty=1, overflow/underflow retained.
- With FIFO_PEAK_EN: fill to 9, drain to 0 -> peak=9. clr_err -> peak=0. Assert rst_n low mid-fill -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and status types for fifo_prog.
//   cnt_w(depth) : width of an occupancy count able to hold 0..depth.
//   ptr_w(depth) : width of a storage index for 0..depth-1 (never below 1).
//   fifo_err_t   : packed {overflow, underflow} sticky error pair, reusable
//                  by status registers that mirror the FIFO error state.
package fifo_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: two-port register array, synchronous write, asynchronous read.
// Kept as its own module so the storage can later be swapped for an SRAM macro.
// Ports:
//   clk   in  rising-edge clock
//   we    in  write enable
//   waddr in  write index (0..DEPTH-1)
//   wdata in  write data
//   raddr in  read index (0..DEPTH-1)
//   rdata out combinational read data at raddr
// Contents are deliberately not reset.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]     rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog.sv
// fifo_prog: single-clock show-ahead FIFO with runtime-programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and support for non-power-of-two DEPTH.
// Optional feature: define FIFO_PEAK_EN to add the `peak` high-water-mark
// output (cleared by reset or clr_err, not by flush).
// Ports:
//   clk, rst_n (async active-low)     clock and reset
//   flush                             synchronous clear of contents
//   wr_en, wr_data                    push request and data
//   rd_en, rd_data                    pop request, head-of-queue data
//   full, empty, count                occupancy status
//   af_thresh, ae_thresh              live threshold inputs
//   almost_full, almost_empty         count >= af_thresh / count <= ae_thresh
//   overflow, underflow, clr_err      sticky errors and their clear
//   peak (FIFO_PEAK_EN only)          highest count seen since last clear
//
// Handshake: the write side is a request (wr_en) accepted when the FIFO has
// room or a pop frees a slot in the same cycle (!full || rd_en); the read
// side presents valid data whenever !empty and rd_en acts as the consumer's
// ready, popping the head at the clock edge. A request that is not accepted
// is dropped and recorded in the matching sticky error flag.
module fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CW         = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
`ifdef FIFO_PEAK_EN
    output logic [CW-1:0]         peak,
`endif
    input  logic                  clr_err
);

    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q, count_nxt;
    logic          push, pop;
    fifo_err_t     err_q, err_set;

    // Flags decode straight from the count register, no extra latency.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;

    // A push at full is still accepted when a pop frees the head slot in the
    // same edge (pass-through). A pop at empty is never accepted, even with a
    // simultaneous push. Flush masks both requests.
    assign push = wr_en && (!full || rd_en) && !flush;
    assign pop  = rd_en && !empty && !flush;

    assign err_set.overflow  = wr_en && full && !rd_en && !flush;
    assign err_set.underflow = rd_en && empty && !flush;

    always_comb begin
        count_nxt = count_q;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count_q + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count_q - CW'(1);
        end
    end

    // Explicit wrap compare so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            err_q   <= '0;
        end else begin
            count_q <= count_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            end
            // A new error in the same cycle as clr_err wins over the clear.
            err_q <= err_set | (err_q & {2{~clr_err}});
        end
    end

    assign overflow  = err_q.overflow;
    assign underflow = err_q.underflow;

`ifdef FIFO_PEAK_EN
    logic [CW-1:0] peak_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (clr_err) begin
            peak_q <= '0;
        end else if (count_nxt > peak_q) begin
            peak_q <= count_nxt;
        end
    end

    assign peak = peak_q;
`endif

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fifo_prog.sv
// tb_fifo_prog: self-checking bench for fifo_prog (DATA_WIDTH=8, DEPTH=12).
// Define FIFO_PEAK_EN on both RTL and bench to cover the peak output.
module tb_fifo_prog;

    localparam int DW    = 8;
    localparam int DEPTH = 12;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          full, empty;
    logic [CW-1:0] count;
    logic [CW-1:0] af_thresh, ae_thresh;
    logic          almost_full, almost_empty;
    logic          overflow, underflow;
    logic          clr_err;
`ifdef FIFO_PEAK_EN
    logic [CW-1:0] peak;
`endif

    fifo_prog #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
`ifdef FIFO_PEAK_EN
        .peak         (peak),
`endif
        .clr_err      (clr_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    logic          m_ovf, m_unf;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every status output against the bench's own occupancy model.
    task automatic check_status(input string tag);
        int n;
        n = exp_q.size();
        check({tag, ".count"}, 32'(count), 32'(n));
        check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= int'(af_thresh)));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= int'(ae_thresh)));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
        if (n > 0) check({tag, ".head"}, 32'(rd_data), 32'(exp_q[0]));
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of stimulus, predicts the outcome, then samples 1ns
    // after the rising edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                        input logic fl, input logic ce, input string tag);
        logic m_full, m_empty, m_push, m_pop;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = fl;
        clr_err = ce;
        m_full  = (exp_q.size() == DEPTH);
        m_empty = (exp_q.size() == 0);
        m_push  = !fl && w && (!m_full || r);
        m_pop   = !fl && r && !m_empty;
        #1;
        if (m_pop) begin
            check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        m_ovf = (!fl && w && m_full && !r) | (m_ovf & ~ce);
        m_unf = (!fl && r && m_empty) | (m_unf & ~ce);
        if (fl) exp_q.delete();
        if (m_push) exp_q.push_back(d);
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        check_status(tag);
    endtask

    task automatic do_push(input logic [DW-1:0] d, input string tag);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic do_pop(input string tag);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, tag);
    endtask

    task automatic do_clr(input string tag);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, tag);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        rd_en     = 1'b0;
        clr_err   = 1'b0;
        af_thresh = CW'(10);
        ae_thresh = CW'(2);
        m_ovf     = 1'b0;
        m_unf     = 1'b0;

        apply_reset();

        // Pop at empty sets underflow; clr_err clears it.
        do_pop("pop_empty");
        check("underflow_set", 32'(underflow), 32'd1);
        do_clr("clr_unf");
        check("underflow_clr", 32'(underflow), 32'd0);

        // Fill 0x00..0x0B, watching thresholds cross.
        for (int k = 0; k < DEPTH; k++) begin
            do_push(DW'(k), "fill");
            if (k == 2) check("ae_off_at_3", 32'(almost_empty), 32'd0);
            if (k == 8) check("af_off_at_9", 32'(almost_full), 32'd0);
            if (k == 9) check("af_on_at_10", 32'(almost_full), 32'd1);
        end
        check("full_at_12", 32'(full), 32'd1);
        do_push(8'hAA, "push_full");
        check("overflow_set", 32'(overflow), 32'd1);

        // Drain in order; 0xAA must never appear.
        for (int k = 0; k < DEPTH; k++) do_pop("drain");
        check("empty_after_drain", 32'(empty), 32'd1);

        // Alternating push/pop, pointers wrap past index 11.
        for (int k = 0; k < 20; k++) begin
            do_push(DW'(8'h80 + k), "alt_push");
            do_pop("alt_pop");
        end

        // Pass-through at full: count stays 12, 0x55 appears after 11 pops.
        for (int k = 0; k < DEPTH; k++) do_push(DW'($urandom_range(0, 255)), "refill");
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, "pass_through");
        check("pt_count", 32'(count), 32'd12);
        for (int k = 0; k < DEPTH - 1; k++) do_pop("pt_drain");
        check("pt_head_55", 32'(rd_data), 32'h55);
        do_pop("pt_last");

        // Push+pop at empty: push only, underflow set.
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, "push_pop_empty");
        check("ppe_head_33", 32'(rd_data), 32'h33);
        check("ppe_underflow", 32'(underflow), 32'd1);

        // Fill to 7 then flush with wr_en: contents gone, errors retained.
        for (int k = 0; k < 6; k++) do_push(DW'(8'h40 + k), "fill7");
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, "flush");
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_ovf_kept", 32'(overflow), 32'd1);

        // Thresholds above DEPTH: almost_full never, almost_empty always.
        af_thresh = CW'(13);
        ae_thresh = CW'(13);
        for (int k = 0; k < DEPTH; k++) do_push(DW'(k + 3), "hi_thresh");
        check("hi_af_never", 32'(almost_full), 32'd0);
        check("hi_ae_always", 32'(almost_empty), 32'd1);
        af_thresh = CW'(10);
        ae_thresh = CW'(2);
        do_clr("clr_all");

        // Random traffic.
        for (int k = 0; k < 200; k++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 15) == 0), "random");
        end

`ifdef FIFO_PEAK_EN
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, "peak_prep");
        check("peak_cleared", 32'(peak), 32'd0);
        for (int k = 0; k < 9; k++) do_push(DW'(k), "peak_fill");
        for (int k = 0; k < 9; k++) do_pop("peak_drain");
        check("peak_9", 32'(peak), 32'd9);
        do_clr("peak_clr");
        check("peak_clr_0", 32'(peak), 32'd0);
`endif

        // Asynchronous reset mid-fill: outputs return without a clock edge.
        for (int k = 0; k < 5; k++) do_push(DW'(k), "pre_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        check_status("async_reset");
`ifdef FIFO_PEAK_EN
        check("async_reset.peak", 32'(peak), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_push(8'h99, "post_reset");
        do_pop("post_reset_pop");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
